// File: rtl/instr_aligner_if.sv
// ============================================================================
// Module      : instr_aligner_if
// Description : Fetch-word and instruction handshake bundle for instr_aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_aligner_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;

    // Aligner side
    modport slave (
        input  fetch_valid,
        input  fetch_data,
        input  flush,
        input  flush_pc,
        input  ins_ready,
        output fetch_ready,
        output ins_valid,
        output ins,
        output ins_pc
    );

    // Fetch unit / decoder side
    modport master (
        output fetch_valid,
        output fetch_data,
        output flush,
        output flush_pc,
        output ins_ready,
        input  fetch_ready,
        input  ins_valid,
        input  ins,
        input  ins_pc
    );
endinterface

`default_nettype wire

// File: rtl/instr_aligner.sv
// ============================================================================
// Module      : instr_aligner
// Description : Halfword realignment buffer; extracts 16/32-bit instructions
//               from word-aligned fetch words and tags each with its PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    instr_aligner_if.slave      bus
);

    localparam logic [2:0] c_DEPTH = 3'd4;

    logic [3:0][15:0] r_hw;
    logic [2:0]       r_cnt;
    logic [31:0]      r_pc;
    logic             r_skip;

    logic             w_is_comp;
    logic             w_ins_valid;
    logic             w_consume;
    logic             w_fetch_ready;
    logic             w_accept;
    logic [2:0]       w_pop_n;
    logic [2:0]       w_push_n;
    logic [2:0]       w_cnt_pop;
    logic [3:0][2:0]  w_src;
    logic [3:0][15:0] w_hw_nxt;
    logic             w_unused_bits;

    // Length decode looks only at the oldest halfword.
    assign w_is_comp     = (r_hw[0][1:0] != 2'b11);
    assign w_ins_valid   = w_is_comp ? (r_cnt >= 3'd1) : (r_cnt >= 3'd2);
    assign w_consume     = w_ins_valid && bus.ins_ready;
    assign w_fetch_ready = (r_cnt <= 3'd2) && !bus.flush;
    assign w_accept      = bus.fetch_valid && w_fetch_ready;

    assign w_pop_n   = w_consume ? (w_is_comp ? 3'd1 : 3'd2) : 3'd0;
    assign w_push_n  = w_accept  ? (r_skip    ? 3'd1 : 3'd2) : 3'd0;
    assign w_cnt_pop = r_cnt - w_pop_n;

    assign w_unused_bits = bus.flush_pc[0];

    // Pop shifts the survivors down; the push then lands right after them.
    always_comb begin
        w_hw_nxt = r_hw;
        w_src    = '0;
        for (int i = 0; i < 4; i++) begin
            w_src[i] = 3'(i) + w_pop_n;
            if (w_src[i] < c_DEPTH) begin
                w_hw_nxt[i] = r_hw[w_src[i][1:0]];
            end
            if (w_accept) begin
                if (3'(i) == w_cnt_pop) begin
                    w_hw_nxt[i] = r_skip ? bus.fetch_data[31:16] : bus.fetch_data[15:0];
                end else if (!r_skip && (3'(i) == (w_cnt_pop + 3'd1))) begin
                    w_hw_nxt[i] = bus.fetch_data[31:16];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 3'd0;
            r_pc   <= RESET_PC;
            r_skip <= RESET_PC[1];
        end else if (bus.flush) begin
            r_cnt  <= 3'd0;
            r_pc   <= {bus.flush_pc[31:1], 1'b0};
            r_skip <= bus.flush_pc[1];
        end else begin
            r_cnt <= w_cnt_pop + w_push_n;
            if (w_consume) begin
                r_pc <= r_pc + (w_is_comp ? 32'd2 : 32'd4);
            end
            if (w_accept && r_skip) begin
                r_skip <= 1'b0;
            end
        end
    end

    // Payload needs no reset; r_cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        r_hw <= w_hw_nxt;
    end

    assign bus.fetch_ready = w_fetch_ready;
    assign bus.ins_valid   = w_ins_valid;
    assign bus.ins         = w_is_comp ? {16'h0000, r_hw[0]} : {r_hw[1], r_hw[0]};
    assign bus.ins_pc      = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_aligner.sv
// ============================================================================
// Module      : tb_instr_aligner
// Description : Scoreboard testbench for instr_aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_aligner;

    logic clk;
    logic rst_n;

    instr_aligner_if bus ();

    instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_ins(input logic [31:0] ins, input logic [31:0] pc);
        exp_q.push_back({ins, pc});
    endtask

    // Monitor: compare every handshake the DUT will complete at the next edge.
    always @(negedge clk) begin
        if (rst_n && !bus.flush && bus.ins_valid && bus.ins_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ins", bus.ins, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_ins", bus.ins, e[63:32]);
                check("sb_pc", bus.ins_pc, e[31:0]);
            end
        end
    end

    task automatic send_word(input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = data;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.fetch_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_flush(input logic [31:0] pc, input logic rdy);
        @(posedge clk); #1;
        bus.flush     = 1'b1;
        bus.flush_pc  = pc;
        bus.ins_ready = rdy;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = '0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        bus.ins_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
        check("rst_ins_pc", bus.ins_pc, 32'h0);
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        bus.flush = 1'b1;
        #1 check("flush_blocks_ready", 32'(bus.fetch_ready), 32'd0);
        bus.flush = 1'b0;

        // Aligned 32-bit code and first-accept latency
        expect_ins(32'h00A00093, 32'h0);
        send_word(32'h00A00093);
        @(negedge clk);
        check("latency_valid", 32'(bus.ins_valid), 32'd1);
        @(posedge clk); #1 bus.ins_ready = 1'b1;
        expect_ins(32'h00100113, 32'h4);
        send_word(32'h00100113);
        drain();

        // Mixed and straddling
        do_reset();
        expect_ins(32'h00004505, 32'h0);
        expect_ins(32'h00A00093, 32'h2);
        expect_ins(32'h00004585, 32'h6);
        send_word(32'h00934505);
        @(negedge clk);
        @(negedge clk);
        check("straddle_wait", 32'(bus.ins_valid), 32'd0);
        send_word(32'h458500A0);
        drain();

        // Flush to odd halfword
        do_flush(32'h0000_0102, 1'b1);
        @(negedge clk);
        check("flush_ins_valid", 32'(bus.ins_valid), 32'd0);
        check("flush_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        check("flush_pc", bus.ins_pc, 32'h102);
        expect_ins(32'h00A00093, 32'h102);
        expect_ins(32'h00004585, 32'h106);
        send_word(32'h00934505);
        send_word(32'h458500A0);
        drain();

        // Backpressure and full
        do_flush(32'h0000_0200, 1'b0);
        for (int k = 0; k < 3; k++) begin
            expect_ins(32'h00004585, 32'h200 + 32'(4 * k));
            expect_ins(32'h00004505, 32'h202 + 32'(4 * k));
        end
        send_word(32'h45054585);
        send_word(32'h45054585);
        fork
            send_word(32'h45054585);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("full_fetch_ready", 32'(bus.fetch_ready), 32'd0);
                end
                @(posedge clk); #1 bus.ins_ready = 1'b1;
            end
        join
        drain();

        // Flush together with handshake and fetch_valid
        do_flush(32'h0000_0280, 1'b0);
        send_word(32'h45054585);
        @(posedge clk); #1;
        bus.ins_ready   = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h00A00093;
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h0000_0300;
        @(negedge clk);
        check("sim_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        check("sim_valid_before", 32'(bus.ins_valid), 32'd1);
        @(posedge clk); #1;
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.ins_ready   = 1'b0;
        @(negedge clk);
        check("sim_pc", bus.ins_pc, 32'h300);
        check("sim_ins_valid", 32'(bus.ins_valid), 32'd0);
        check("sim_fetch_ready_after", 32'(bus.fetch_ready), 32'd1);
        @(negedge clk);
        check("sim_no_accept", 32'(bus.ins_valid), 32'd0);

        // Reset overrides flush
        @(posedge clk); #1;
        rst_n        = 1'b0;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0400;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("rst_over_flush_pc", bus.ins_pc, 32'h0);
        check("rst_over_flush_valid", 32'(bus.ins_valid), 32'd0);

        // PC wrap
        do_flush(32'hFFFF_FFFE, 1'b0);
        expect_ins(32'h00000000, 32'hFFFF_FFFE);
        send_word(32'h00004505);
        @(negedge clk);
        check("wrap_valid", 32'(bus.ins_valid), 32'd1);
        check("wrap_pc_before", bus.ins_pc, 32'hFFFF_FFFE);
        @(posedge clk); #1 bus.ins_ready = 1'b1;
        @(posedge clk); #1 bus.ins_ready = 1'b0;
        @(negedge clk);
        check("wrap_pc_after", bus.ins_pc, 32'h0);
        check("wrap_empty", 32'(bus.ins_valid), 32'd0);
        expect_ins(32'h00004585, 32'h0);
        expect_ins(32'h00004505, 32'h2);
        @(posedge clk); #1 bus.ins_ready = 1'b1;
        send_word(32'h45054585);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
